// File: rtl/seq_counter_ctrl.sv
// seq_counter_ctrl: run/pause/abort controller for the bounded sequence counter.
// Owns the programmable low/high bounds and the loop budget, and produces
// count plus one-cycle wrap/done pulses for downstream sequencing.
// Optional build macro: SEQ_CTRL_DOWN_EN adds cfg_down to select down-counting.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | stopped; config accepted, start honoured, count parked
// ST_RUN   | counting one step per cycle between the bounds
// ST_PAUSE | count frozen until pause drops or abort arrives
module seq_counter_ctrl #(
  parameter int WIDTH   = 3,
  parameter int LOOPS_W = 8,
  parameter int DEF_LO  = 2,
  parameter int DEF_HI  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_lo,
  input  logic [WIDTH-1:0]   cfg_hi,
  input  logic [LOOPS_W-1:0] cfg_loops,
`ifdef SEQ_CTRL_DOWN_EN
  input  logic               cfg_down,
`endif
  output logic               cfg_err,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  output logic [WIDTH-1:0]   count,
  output logic               wrap,
  output logic               done,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_count;
  logic [LOOPS_W-1:0] r_loops;
  logic [LOOPS_W-1:0] r_loop_cnt;
  logic               r_wrap;
  logic               r_done;
  logic               r_cfg_err;

  logic               w_down;
  logic               w_cfg_down;
  logic               w_cfg_ok;
  logic [WIDTH-1:0]   w_cfg_start;
  logic [WIDTH-1:0]   w_restart;
  logic [WIDTH-1:0]   w_step;
  logic               w_at_end;
  logic               w_in_range;
  logic [LOOPS_W:0]   w_loop_inc;
  logic               w_terminal;
  logic [LOOPS_W-1:0] w_loop_sat;

`ifdef SEQ_CTRL_DOWN_EN
  logic r_down;

  // Direction flag, captured only together with an accepted config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_down <= 1'b0;
    end else if (r_state == ST_IDLE && cfg_valid && w_cfg_ok) begin
      r_down <= cfg_down;
    end
  end

  assign w_down     = r_down;
  assign w_cfg_down = cfg_down;
`else
  assign w_down     = 1'b0;
  assign w_cfg_down = 1'b0;
`endif

  // Step decode: the "end" of the sequence is hi when counting up and lo when
  // counting down; restart is where the count lands after wrap/abort/recovery.
  always_comb begin
    w_cfg_ok    = (cfg_lo <= cfg_hi);
    w_cfg_start = w_cfg_down ? cfg_hi : cfg_lo;
    w_restart   = w_down ? r_hi : r_lo;
    w_at_end    = w_down ? (r_count == r_lo) : (r_count == r_hi);
    w_in_range  = w_down ? ((r_count > r_lo) && (r_count <= r_hi))
                         : ((r_count >= r_lo) && (r_count < r_hi));
    w_step      = w_down ? (r_count - 1'b1) : (r_count + 1'b1);
    // One extra bit so the budget compare cannot alias when loop_cnt is at max.
    w_loop_inc  = {1'b0, r_loop_cnt} + 1'b1;
    w_terminal  = (r_loops != '0) && (w_loop_inc == {1'b0, r_loops});
    w_loop_sat  = (&r_loop_cnt) ? r_loop_cnt : w_loop_inc[LOOPS_W-1:0];
  end

  // Controller FSM with registered count and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lo       <= WIDTH'(DEF_LO);
      r_hi       <= WIDTH'(DEF_HI);
      r_loops    <= '0;
      r_loop_cnt <= '0;
      r_count    <= WIDTH'(DEF_LO);
      r_wrap     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (w_cfg_ok) begin
              r_lo    <= cfg_lo;
              r_hi    <= cfg_hi;
              r_loops <= cfg_loops;
              r_count <= w_cfg_start;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
          // Count is already parked at the restart value, so start only
          // changes state; a same-cycle config has updated it above.
          if (start) begin
            r_state    <= ST_RUN;
            r_loop_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state    <= ST_IDLE;
            r_count    <= w_restart;
            r_loop_cnt <= '0;
          end else if (pause) begin
            r_state <= ST_PAUSE;
          end else if (w_at_end) begin
            r_count    <= w_restart;
            r_wrap     <= 1'b1;
            r_loop_cnt <= w_loop_sat;
            if (w_terminal) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else if (w_in_range) begin
            r_count <= w_step;
          end else begin
            r_count <= w_restart;
          end
        end
        ST_PAUSE: begin
          if (abort) begin
            r_state    <= ST_IDLE;
            r_count    <= w_restart;
            r_loop_cnt <= '0;
          end else if (!pause) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign count     = r_count;
  assign wrap      = r_wrap;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Bench for seq_counter_ctrl: directed vector table, a mid-run reset
// sequence, then random stimulus against a behavioural model.
module tb_seq_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_lo = '0;
  logic [2:0] cfg_hi = '0;
  logic [7:0] cfg_loops = '0;
  logic       cfg_err;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] count;
  logic       wrap;
  logic       done;
  logic       busy;
`ifdef SEQ_CTRL_DOWN_EN
  logic       cfg_down = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  seq_counter_ctrl #(.WIDTH(3), .LOOPS_W(8), .DEF_LO(2), .DEF_HI(6)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_loops(cfg_loops),
`ifdef SEQ_CTRL_DOWN_EN
    .cfg_down(cfg_down),
`endif
    .cfg_err(cfg_err), .start(start), .pause(pause), .abort(abort),
    .count(count), .wrap(wrap), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [2:0] lo;
    logic [2:0] hi;
    logic [7:0] loops;
    logic       st;
    logic       pa;
    logic       ab;
    logic [2:0] e_cnt;
    logic       e_wrap;
    logic       e_done;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic cv, input logic [2:0] lo, input logic [2:0] hi,
                             input logic [7:0] loops, input logic st, input logic pa,
                             input logic ab, input logic [2:0] e_cnt, input logic e_wrap,
                             input logic e_done, input logic e_busy, input logic e_err);
    vec_t r;
    r.cv = cv; r.lo = lo; r.hi = hi; r.loops = loops; r.st = st; r.pa = pa; r.ab = ab;
    r.e_cnt = e_cnt; r.e_wrap = e_wrap; r.e_done = e_done; r.e_busy = e_busy; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [2:0] lo, input logic [2:0] hi,
                       input logic [7:0] lp, input logic st, input logic pa, input logic ab);
    cfg_valid = cv; cfg_lo = lo; cfg_hi = hi; cfg_loops = lp;
    start = st; pause = pa; abort = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_cnt, input logic e_wrap,
                         input logic e_done, input logic e_busy, input logic e_err);
    chk({tag, " count"}, 32'(count), 32'(e_cnt));
    chk({tag, " wrap"}, 32'(wrap), 32'(e_wrap));
    chk({tag, " done"}, 32'(done), 32'(e_done));
    chk({tag, " busy"}, 32'(busy), 32'(e_busy));
    chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'(!e_busy));
    chk({tag, " cfg_err"}, 32'(cfg_err), 32'(e_err));
  endtask

  // Behavioural model: the count is an offset into a ring of (hi-lo+1)
  // positions; wraps are tallied against the budget.
  int m_lo, m_hi, m_loops, m_cnt, m_wraps;
  bit m_active, m_paused;
  bit e_wrap, e_done, e_err;

  task automatic model_reset();
    m_lo = 2; m_hi = 6; m_loops = 0; m_cnt = 2; m_wraps = 0;
    m_active = 0; m_paused = 0;
    e_wrap = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step(input int cv, input int lo, input int hi, input int lp,
                            input bit st, input bit pa, input bit ab);
    int span, off;
    e_wrap = 0; e_done = 0; e_err = 0;
    if (!m_active) begin
      if (cv != 0) begin
        if (lo <= hi) begin
          m_lo = lo; m_hi = hi; m_loops = lp; m_cnt = lo;
        end else begin
          e_err = 1;
        end
      end
      if (st) begin
        m_active = 1; m_paused = 0; m_wraps = 0;
      end
    end else if (ab) begin
      m_active = 0; m_paused = 0; m_cnt = m_lo; m_wraps = 0;
    end else if (m_paused) begin
      if (!pa) m_paused = 0;
    end else if (pa) begin
      m_paused = 1;
    end else begin
      span = m_hi - m_lo + 1;
      if (m_cnt >= m_lo && m_cnt <= m_hi) begin
        off = (m_cnt - m_lo + 1) % span;
        m_cnt = m_lo + off;
        if (off == 0) begin
          e_wrap = 1;
          m_wraps++;
          if (m_loops != 0 && m_wraps == m_loops) begin
            e_done = 1;
            m_active = 0;
          end
        end
      end else begin
        m_cnt = m_lo;
      end
    end
  endtask

  initial begin
    // Directed vectors: inputs applied before an edge, outputs expected after it.
    vecs.push_back(v(0,0,0,0, 1,0,0, 2,0,0,1,0));  // 1 start on defaults
    vecs.push_back(v(0,0,0,0, 0,0,0, 3,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 4,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 5,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 6,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 2,1,0,1,0));  // 6 wrap 6->2
    vecs.push_back(v(0,0,0,0, 0,0,0, 3,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,1, 2,0,0,0,0));  // 8 abort
    vecs.push_back(v(1,5,2,0, 0,0,0, 2,0,0,0,1));  // 9 rejected config
    vecs.push_back(v(0,0,0,0, 0,0,0, 2,0,0,0,0));
    vecs.push_back(v(1,1,3,2, 1,0,0, 1,0,0,1,0));  // 11 cfg 1..3 x2 + start
    vecs.push_back(v(0,0,0,0, 0,0,0, 2,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 3,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 1,1,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 2,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 3,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 1,1,1,0,0));  // 17 terminal wrap
    vecs.push_back(v(0,0,0,0, 0,0,0, 1,0,0,0,0));
    vecs.push_back(v(1,2,6,0, 1,0,0, 2,0,0,1,0));  // 19 back to 2..6 forever
    vecs.push_back(v(0,0,0,0, 0,0,0, 3,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 4,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,1,0, 4,0,0,1,0));  // 22 pause at 4
    vecs.push_back(v(0,0,0,0, 0,1,0, 4,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,1,0, 4,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 4,0,0,1,0));  // 25 resume edge, held
    vecs.push_back(v(0,0,0,0, 0,0,0, 5,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 6,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 2,1,0,1,0));
    vecs.push_back(v(1,0,7,0, 0,0,0, 3,0,0,1,0));  // 29 config while running ignored
    vecs.push_back(v(0,0,0,0, 0,0,0, 4,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 5,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,1,1, 2,0,0,0,0));  // 32 abort beats pause
    vecs.push_back(v(1,7,1,0, 1,0,0, 2,0,0,1,1));  // 33 start with rejected cfg
    vecs.push_back(v(0,0,0,0, 0,0,0, 3,0,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,1, 2,0,0,0,0));
    vecs.push_back(v(1,4,4,3, 1,0,0, 4,0,0,1,0));  // 36 lo == hi, 3 loops
    vecs.push_back(v(0,0,0,0, 0,0,0, 4,1,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 4,1,0,1,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 4,1,1,0,0));
    vecs.push_back(v(0,0,0,0, 0,0,0, 4,0,0,0,0));
    vecs.push_back(v(0,0,0,0, 0,0,1, 4,0,0,0,0));  // 41 abort in idle

    // Reset state.
    tick(); tick();
    chk_all("reset", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].cv, vecs[i].lo, vecs[i].hi, vecs[i].loops, vecs[i].st, vecs[i].pa, vecs[i].ab);
      tick();
      chk_all($sformatf("row%0d", i + 1), vecs[i].e_cnt, vecs[i].e_wrap,
              vecs[i].e_done, vecs[i].e_busy, vecs[i].e_err);
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // Mid-run reset drops the programmed bounds immediately.
    drive(1, 1, 5, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("midrst pre count", 32'(count), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst async count", 32'(count), 32'd2);
    chk("midrst async busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("midrst restart count", 32'(count), 32'd2);
    repeat (4) tick();
    chk("midrst default hi", 32'(count), 32'd6);
    tick();
    chk("midrst default wrap count", 32'(count), 32'd2);
    chk("midrst default wrap", 32'(wrap), 32'd1);

    // Random phase against the model, from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic       r_cv, r_st, r_pa, r_ab;
      logic [2:0] r_lo, r_hi;
      logic [7:0] r_lp;
      r_cv = ($urandom_range(0, 5) == 0);
      r_lo = 3'($urandom_range(0, 7));
      r_hi = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && r_lo > r_hi) begin
        logic [2:0] t;
        t = r_lo; r_lo = r_hi; r_hi = t;
      end
      r_lp = 8'($urandom_range(0, 4));
      r_st = ($urandom_range(0, 2) == 0);
      r_pa = ($urandom_range(0, 5) == 0);
      r_ab = ($urandom_range(0, 30) == 0);
      drive(r_cv, r_lo, r_hi, r_lp, r_st, r_pa, r_ab);
      model_step(int'(r_cv), int'(r_lo), int'(r_hi), int'(r_lp), r_st, r_pa, r_ab);
      tick();
      chk_all($sformatf("rand%0d", n), 3'(m_cnt), e_wrap, e_done, m_active, e_err);
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_counter_ctrl.md
Name: seq_counter_ctrl

Overview:
- Controller for the team's bounded sequence counter: owns the programmable low/high bounds, the loop budget and a run/pause/abort FSM.
- Produces the count value plus wrap/done events for downstream sequencing logic.
- Sits between the configuration/command master and any logic consuming the cyclic count, e.g. the 2..6 sequence.

Parameters:
- WIDTH, 3, count and bound width.
- LOOPS_W, 8, width of loop budget and loop counter.
- DEF_LO, 2, low bound after reset.
- DEF_HI, 6, high bound after reset.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted this cycle when cfg_valid & cfg_ready.
- cfg_lo  input  WIDTH  requested low bound.
- cfg_hi  input  WIDTH  requested high bound.
- cfg_loops  input  LOOPS_W  wraps before auto-stop; 0 = run forever.
- cfg_err  output  1  one-cycle pulse: rejected config (cfg_lo > cfg_hi).
- start  input  1  begin counting; honoured only in IDLE.
- pause  input  1  level; hold count while high.
- abort  input  1  return to IDLE immediately.
- count  output  WIDTH  current count value.
- wrap  output  1  one-cycle pulse in the cycle count shows lo after a hi->lo transition.
- done  output  1  one-cycle pulse when the loop budget is exhausted.
- busy  output  1  state != IDLE.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - state IDLE.
  - lo_r = DEF_LO, hi_r = DEF_HI, loops_r = 0, loop_cnt = 0.
  - count = DEF_LO.
  - wrap = done = cfg_err = busy = 0.
  - cfg_ready = 1.
- States: IDLE, RUN, PAUSE (2-bit encoding).
- cfg_ready = (state == IDLE), combinational.
- On cfg handshake:
  - If cfg_lo <= cfg_hi: register lo_r, hi_r, loops_r; count <= cfg_lo at the same edge.
  - Else: cfg_err = 1 next cycle; registers unchanged.
- IDLE + start -> RUN at the next edge; loop_cnt <= 0; count holds lo_r.
  - cfg and start in the same cycle: both taken; the run uses the new bounds and count = cfg_lo.
  - start with a rejected config in the same cycle: start still taken, old bounds used.
- RUN, each cycle:
  - If count == hi_r: count <= lo_r; wrap = 1 next cycle; loop_cnt += 1.
  - Else if lo_r <= count < hi_r: count <= count + 1.
  - Else (out of range, recovery only): count <= lo_r, no wrap.
- Terminal wrap: loops_r != 0 and loop_cnt + 1 == loops_r at a hi->lo step.
  - State -> IDLE; count <= lo_r.
  - wrap and done both pulse next cycle; busy = 0 from that cycle.
- lo_r == hi_r: count constant; wrap every RUN cycle; done after loops_r cycles.
- Pause:
  - RUN + pause -> PAUSE; count frozen at the current value (no increment that edge).
  - PAUSE + !pause -> RUN; counting resumes from the held value next edge.
  - No wrap/done pulses while paused.
- abort (RUN or PAUSE) -> IDLE; count <= lo_r; loop_cnt <= 0; no done, no wrap.
- Priority: rst > abort > pause > count/wrap logic. start outside IDLE is ignored. abort in IDLE has no effect.
- loop_cnt saturates at its maximum when loops_r == 0; no overflow.
- Arithmetic is unsigned, WIDTH bits; count never exceeds hi_r in normal operation.
- rst mid-run: all registers take reset values immediately; programmed config is lost.

Optional Feature:
- Macro: SEQ_CTRL_DOWN_EN.
- Defined:
  - Extra input cfg_down (1 bit), captured with config into down_r (reset 0).
  - When down_r = 1:
    - Config accept and abort load count = hi_r.
    - RUN decrements; at count == lo_r the next count is hi_r and wrap/loop/done rules apply to that step.
    - Out-of-range recovery loads hi_r.
- Undefined: no cfg_down port; up-counting only.

Test Plan:
- Reset, no config; start with loops=0 -> count 2,3,4,5,6,2,3...; wrap high the cycle count returns to 2; busy=1; done never.
- Config lo=1, hi=3, loops=2; start -> count 1,2,3,1,2,3,1; wrap on both returns to 1; done with the second wrap; busy=0 after.
- RUN at count=4 (defaults), pause held 3 cycles -> count stays 4 for 3 cycles, then 5,6,2; no wrap while paused.
- Config lo=5, hi=2 -> cfg_err one cycle, bounds stay 2/6; config during RUN -> cfg_ready=0, not accepted.
- abort at count=5 -> next cycle IDLE, count=2, done=0; abort together with pause -> abort wins.
- With SEQ_CTRL_DOWN_EN: config lo=2, hi=6, down=1, loops=1 -> count 6,5,4,3,2,6; done with the wrap to 6.
